// File: rtl/gray_conv_arbiter.sv
// Two-requester arbiter feeding a bit-serial Gray-to-binary converter.
// Winner's code is resolved MSB first, one bit per clock, then held until the consumer takes it.
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_gray,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_gray,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_binary,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       conv_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             id_q, id_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;

  logic             grant;
  logic             take0, take1;
  logic [WIDTH-1:0] upper;
  logic [CW-1:0]    idx;

  always_comb begin
    grant = prio_q;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
    take0 = (state_q == IDLE) && req0_valid && !grant;
    take1 = (state_q == IDLE) && req1_valid && grant;
  end

  // Readies are gated by rst_n so they fall immediately when reset asserts.
  assign req0_ready = rst_n & take0;
  assign req1_ready = rst_n & take1;

  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    bin_d   = bin_q;
    id_d    = id_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    // Zero above the MSB makes the top bit resolve to the Gray bit itself.
    upper   = {1'b0, bin_q[WIDTH-1:1]};
    idx     = LAST - cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take0) begin
          gray_d  = req0_gray;
          id_d    = 1'b0;
          prio_d  = 1'b1;
          cnt_d   = '0;
          state_d = CONV;
        end else if (take1) begin
          gray_d  = req1_gray;
          id_d    = 1'b1;
          prio_d  = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_d[idx] = upper[idx] ^ gray_q[idx];
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          count_d = count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gray_q  <= '0;
      bin_q   <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_binary = bin_q;
  assign out_id     = id_q;
  assign conv_count = count_q;

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, code width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has a Gray code pending.
REQ-005 SHALL have port: req0_gray  input  WIDTH  requester 0 Gray code.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 accepted this cycle.
REQ-007 SHALL have port: req1_valid  input  1  requester 1 has a Gray code pending.
REQ-008 SHALL have port: req1_gray  input  WIDTH  requester 1 Gray code.
REQ-009 SHALL have port: req1_ready  output  1  requester 1 accepted this cycle.
REQ-010 SHALL have port: out_valid  output  1  converted result available.
REQ-011 SHALL have port: out_binary  output  WIDTH  binary result.
REQ-012 SHALL have port: out_id  output  1  requester that owns the result.
REQ-013 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port: conv_count  output  8  number of completed result handshakes, modulo 256.

Function
REQ-016 SHALL implement the FSM IDLE -> CONV -> DONE -> IDLE, with no other states.
REQ-017 SHALL evaluate arbitration in IDLE only.
- Grant = the single valid requester.
- If both are valid, grant = the requester holding priority (prio).
REQ-018 SHALL drive reqN_ready combinationally high only in IDLE, when reqN_valid=1 and N is granted, so at most one ready is high per cycle.
REQ-019 SHALL perform the following on an accept edge (reqN_valid & reqN_ready):
- capture reqN_gray and out_id=N;
- set prio to the other requester;
- clear the bit counter;
- enter CONV.
REQ-020 SHALL resolve in CONV one bit per cycle, MSB first:
- out_binary[WIDTH-1] = gray[WIDTH-1];
- out_binary[i] = out_binary[i+1] XOR gray[i].
REQ-021 SHALL enter DONE exactly WIDTH edges after the accept edge, and assert out_valid from that edge onward.
REQ-022 SHALL hold out_valid, out_binary and out_id stable in DONE until out_ready=1.
REQ-023 SHALL, on the edge where out_valid & out_ready:
- return to IDLE;
- deassert out_valid;
- increment conv_count, wrapping from 255 to 0.
REQ-024 SHALL change out_binary only during CONV, so it holds the last result in IDLE.
REQ-025 SHALL never accept a new request while busy=1, giving a maximum throughput of one result per WIDTH+2 cycles.
REQ-026 SHALL have no effect on state or prio when a requester drops valid before it is granted.
REQ-027 SHALL ignore changes on reqN_gray after the accept edge.
REQ-028 SHALL ignore out_ready outside DONE.

Reset
REQ-029 SHALL, while rst_n=0, immediately (without waiting for a clock edge) set:
- state=IDLE, out_valid=0, out_binary=0, out_id=0;
- conv_count=0, prio=requester 0, bit counter=0;
- busy=0, and both ready outputs=0.
REQ-030 SHALL, when reset asserts mid-CONV or mid-DONE, discard the partial or pending result with no handshake and no conv_count increment.
REQ-031 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Verification (WIDTH=4)
REQ-032 SHALL cover reset: drive rst_n=0 between edges with both valids high -> out_valid=0, out_binary=0000, conv_count=0, req0_ready=req1_ready=0, without waiting for a clock edge.
REQ-033 SHALL cover a single request: req0 gray=0110 -> accept, then exactly 4 edges later out_valid=1, out_binary=0100, out_id=0; with out_ready=1, conv_count=1.
REQ-034 SHALL cover contention:
- stimulus: immediately after reset, req0=1111 and req1=0111 both valid and held;
- response: req0 served first (1010, id 0), then req1 (0101, id 1);
- a subsequent third simultaneous request goes to req0.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_binary and out_id stable, both readys 0, busy=1; release -> handshake, then IDLE.
REQ-036 SHALL cover reset mid-operation: rst_n pulsed low 2 cycles after accept of req1=1000 -> out_valid=0, busy=0, conv_count unchanged, prio=req0.
REQ-037 SHALL cover counter wrap: 256 back-to-back completed conversions -> conv_count returns to 0.
